tri_fill: RTL and testbench

- Filled-triangle scanline generator for the 2D graphics pipeline.
- Sorts three vertices by y and walks the long edge and the two short edges one row at a time.
- For every row it emits one horizontal span (x0, x1, y), with handshake, to the downstream fast horizontal-line drawer (fline), which rasterises the span.
- Waits for that drawer's done pulse before producing the next row.

---
 rtl/tri_fill.sv | 262 ++++++++++++++++++++++++++
 tb/tb_tri_fill.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_fill.sv
// ---------------------------------------------------------------------------
// tri_fill: filled-triangle scanline generator.
//
// Sorts the three vertices by y (stable) and walks the long edge a->c together
// with the short edge a->b and then b->c, one row at a time. Each row becomes
// one horizontal span handed to the downstream horizontal-line drawer.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               begin a triangle (sampled only when idle)
//   vx0..vy2            signed vertex coordinates, latched on start
//   line_done           one-tick done pulse from the line drawer
//   line_x0, line_x1    span left/right (line_x0 <= line_x1)
//   y                   row of the current span
//   line_start          one-tick span request to the line drawer
//   busy                triangle in progress
//   done                one-tick completion pulse
//
// Span handshake: line_start is high for exactly one cycle with line_x0,
// line_x1 and y valid; those outputs then stay frozen until the drawer
// answers with a one-cycle line_done. Only one span is ever outstanding, and
// line_done seen while no span is outstanding is ignored.
// ---------------------------------------------------------------------------
module tri_fill #(
    parameter int CORDW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [CORDW-1:0] vx0,
    input  logic signed [CORDW-1:0] vy0,
    input  logic signed [CORDW-1:0] vx1,
    input  logic signed [CORDW-1:0] vy1,
    input  logic signed [CORDW-1:0] vx2,
    input  logic signed [CORDW-1:0] vy2,
    input  logic                    line_done,
    output logic signed [CORDW-1:0] line_x0,
    output logic signed [CORDW-1:0] line_x1,
    output logic signed [CORDW-1:0] y,
    output logic                    line_start,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SORT1 = 3'd1,
        SORT2 = 3'd2,
        INIT  = 3'd3,
        EMIT  = 3'd4,
        WAIT  = 3'd5,
        STEP  = 3'd6
    } state_t;

    localparam logic signed [CORDW-1:0] ONE = 1;

    state_t state;

    // Vertex registers; after SORT2 they hold a, b, c in y order.
    logic signed [CORDW-1:0] ax, ay, bx, by, cx, cy;

    // Long edge (a->c) walker.
    logic signed [CORDW-1:0] xl;
    logic        [CORDW-1:0] dxl, dyl;
    logic        [CORDW:0]   errl;
    logic                    negl;

    // Short edge walker: a->b first, reloaded with b->c after row yb.
    logic signed [CORDW-1:0] xs;
    logic        [CORDW-1:0] dxs, dys;
    logic        [CORDW:0]   errs;
    logic                    negs;

    // First STEP cycle adds |dx| to the error terms; later cycles take x steps.
    logic adding;

    function automatic logic [CORDW-1:0] mag(input logic signed [CORDW-1:0] d);
        return d[CORDW-1] ? -d : d;
    endfunction

    function automatic logic signed [CORDW-1:0] smin(input logic signed [CORDW-1:0] p,
                                                     input logic signed [CORDW-1:0] q);
        return (p < q) ? p : q;
    endfunction

    function automatic logic signed [CORDW-1:0] smax(input logic signed [CORDW-1:0] p,
                                                     input logic signed [CORDW-1:0] q);
        return (p > q) ? p : q;
    endfunction

    // Second sort cycle: compare-swap (b,c) then (a,b). Strict compares keep
    // equal-y vertices in input order.
    logic signed [CORDW-1:0] s_ax, s_ay, s_bx, s_by, s_cx, s_cy;
    logic signed [CORDW-1:0] t_bx, t_by;

    always_comb begin
        t_bx = bx;
        t_by = by;
        s_cx = cx;
        s_cy = cy;
        if (by > cy) begin
            t_bx = cx;
            t_by = cy;
            s_cx = bx;
            s_cy = by;
        end
        s_ax = ax;
        s_ay = ay;
        s_bx = t_bx;
        s_by = t_by;
        if (ay > t_by) begin
            s_ax = t_bx;
            s_ay = t_by;
            s_bx = ax;
            s_by = ay;
        end
    end

    // Span of the row about to be emitted. The walkers supply the long and
    // short edge x; xb joins at row yb (both short edges meet there, and it is
    // the far end of a flat a->b edge) and xc joins at row yc (the far end of
    // a flat b->c or a flat long edge). In INIT the walkers are not loaded yet,
    // so vertex a stands in for both.
    logic signed [CORDW-1:0] row_y, px, qx, span_lo, span_hi;

    always_comb begin
        if (state == INIT) begin
            row_y = ay;
            px    = ax;
            qx    = ax;
        end else begin
            row_y = y;
            px    = xl;
            qx    = xs;
        end
        span_lo = smin(px, qx);
        span_hi = smax(px, qx);
        if (row_y == by) begin
            span_lo = smin(span_lo, bx);
            span_hi = smax(span_hi, bx);
        end
        if (row_y == cy) begin
            span_lo = smin(span_lo, cx);
            span_hi = smax(span_hi, cx);
        end
    end

    // A zero-height edge never steps; guarding dy != 0 keeps the loop finite.
    logic step_l, step_s;
    assign step_l = (dyl != '0) && (errl >= {1'b0, dyl});
    assign step_s = (dys != '0) && (errs >= {1'b0, dys});

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            line_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            adding     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ax    <= vx0;
                        ay    <= vy0;
                        bx    <= vx1;
                        by    <= vy1;
                        cx    <= vx2;
                        cy    <= vy2;
                        busy  <= 1'b1;
                        state <= SORT1;
                    end
                end
                SORT1: begin
                    if (ay > by) begin
                        ax <= bx;
                        ay <= by;
                        bx <= ax;
                        by <= ay;
                    end
                    state <= SORT2;
                end
                SORT2: begin
                    ax    <= s_ax;
                    ay    <= s_ay;
                    bx    <= s_bx;
                    by    <= s_by;
                    cx    <= s_cx;
                    cy    <= s_cy;
                    state <= INIT;
                end
                INIT: begin
                    xl         <= ax;
                    dxl        <= mag(cx - ax);
                    negl       <= (cx < ax);
                    dyl        <= cy - ay;
                    errl       <= '0;
                    xs         <= ax;
                    dxs        <= mag(bx - ax);
                    negs       <= (bx < ax);
                    dys        <= by - ay;
                    errs       <= '0;
                    y          <= ay;
                    line_x0    <= span_lo;
                    line_x1    <= span_hi;
                    line_start <= 1'b1;
                    state      <= EMIT;
                end
                EMIT: begin
                    line_start <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (line_done) begin
                        if (y == cy) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            adding <= 1'b1;
                            state  <= STEP;
                        end
                    end
                end
                STEP: begin
                    if (adding) begin
                        adding <= 1'b0;
                        y      <= y + ONE;
                        errl   <= errl + {1'b0, dxl};
                        if (y == by) begin
                            // Leaving row yb: the short edge becomes b->c.
                            xs   <= bx;
                            dxs  <= mag(cx - bx);
                            negs <= (cx < bx);
                            dys  <= cy - by;
                            errs <= {1'b0, mag(cx - bx)};
                        end else begin
                            errs <= errs + {1'b0, dxs};
                        end
                    end else if (step_l || step_s) begin
                        if (step_l) begin
                            errl <= errl - {1'b0, dyl};
                            xl   <= negl ? xl - ONE : xl + ONE;
                        end
                        if (step_s) begin
                            errs <= errs - {1'b0, dys};
                            xs   <= negs ? xs - ONE : xs + ONE;
                        end
                    end else begin
                        line_x0    <= span_lo;
                        line_x1    <= span_hi;
                        line_start <= 1'b1;
                        state      <= EMIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_fill.sv
// ---------------------------------------------------------------------------
// tb_tri_fill: self-checking bench for tri_fill. A reference model builds the
// expected span list straight from the edge equations (integer division,
// which truncates toward zero); a drawer model answers each span after a
// random delay while the outputs are checked for stability.
// ---------------------------------------------------------------------------
module tb_tri_fill;

    logic clk;
    logic rst;
    logic start;
    logic signed [15:0] vx0, vy0, vx1, vy1, vx2, vy2;
    logic line_done;
    logic signed [15:0] line_x0, line_x1, y;
    logic line_start, busy, done;

    logic [47:0] exp_q[$];
    int n_checks;
    int n_fail;

    tri_fill #(.CORDW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .vx0        (vx0),
        .vy0        (vy0),
        .vx1        (vx1),
        .vy1        (vy1),
        .vx2        (vx2),
        .vy2        (vy2),
        .line_done  (line_done),
        .line_x0    (line_x0),
        .line_x1    (line_x1),
        .y          (y),
        .line_start (line_start),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int edge_x(input int xs, input int ys, input int xe, input int ye, input int r);
        return xs + ((r - ys) * (xe - xs)) / (ye - ys);
    endfunction

    task automatic model(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2);
        int ix[3];
        int iy[3];
        int t;
        ix[0] = x0; iy[0] = y0;
        ix[1] = x1; iy[1] = y1;
        ix[2] = x2; iy[2] = y2;
        // Bubble sort with strict compare is stable.
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2 - i; j++) begin
                if (iy[j] > iy[j+1]) begin
                    t = ix[j]; ix[j] = ix[j+1]; ix[j+1] = t;
                    t = iy[j]; iy[j] = iy[j+1]; iy[j+1] = t;
                end
            end
        end
        for (int r = iy[0]; r <= iy[2]; r++) begin
            int xq[$];
            int lo, hi;
            if (iy[0] == iy[2]) begin
                xq.push_back(ix[0]);
                xq.push_back(ix[2]);
            end else begin
                xq.push_back(edge_x(ix[0], iy[0], ix[2], iy[2], r));
            end
            if (r <= iy[1]) begin
                if (iy[0] == iy[1]) begin
                    xq.push_back(ix[0]);
                    xq.push_back(ix[1]);
                end else begin
                    xq.push_back(edge_x(ix[0], iy[0], ix[1], iy[1], r));
                end
            end
            if (r >= iy[1]) begin
                if (iy[1] == iy[2]) begin
                    xq.push_back(ix[1]);
                    xq.push_back(ix[2]);
                end else begin
                    xq.push_back(edge_x(ix[1], iy[1], ix[2], iy[2], r));
                end
            end
            lo = xq[0];
            hi = xq[0];
            foreach (xq[k]) begin
                if (xq[k] < lo) lo = xq[k];
                if (xq[k] > hi) hi = xq[k];
            end
            exp_q.push_back({16'(lo), 16'(hi), 16'(r)});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ls(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (line_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start(input int x0, input int y0, input int x1, input int y1,
                               input int x2, input int y2);
        vx0 = 16'(x0); vy0 = 16'(y0);
        vx1 = 16'(x1); vy1 = 16'(y1);
        vx2 = 16'(x2); vy2 = 16'(y2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble the inputs; the DUT must use the latched copy.
        vx0 = 16'($urandom_range(0, 200)); vy0 = 16'($urandom_range(0, 200));
        vx1 = 16'($urandom_range(0, 200)); vy1 = 16'($urandom_range(0, 200));
        vx2 = 16'($urandom_range(0, 200)); vy2 = 16'($urandom_range(0, 200));
    endtask

    task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int dmax, input bit poke);
        bit ok;
        int d;
        logic [47:0] got;
        logic [47:0] exp;
        model(x0, y0, x1, y1, x2, y2);
        pulse_start(x0, y0, x1, y1, x2, y2);
        while (exp_q.size() > 0) begin
            wait_ls(ok);
            check("line_start_seen", {63'b0, ok}, 64'd1);
            if (!ok) begin
                exp_q.delete();
                return;
            end
            exp = exp_q.pop_front();
            got = {line_x0, line_x1, y};
            check("span", {16'b0, got}, {16'b0, exp});
            check("x0_le_x1", {63'b0, (line_x0 <= line_x1)}, 64'd1);
            check("busy_on_span", {63'b0, busy}, 64'd1);
            d = $urandom_range(0, dmax);
            if (poke && d < 1) d = 1;
            for (int k = 0; k <= d; k++) begin
                @(negedge clk);
                start = poke && (k == 0);
                check("span_hold", {16'b0, line_x0, line_x1, y}, {16'b0, got});
                check("no_line_start_wait", {63'b0, line_start}, 64'd0);
                check("busy_wait", {63'b0, busy}, 64'd1);
                check("done_low_wait", {63'b0, done}, 64'd0);
            end
            start = 1'b0;
            line_done = 1'b1;
            @(negedge clk);
            line_done = 1'b0;
        end
        check("done_pulse", {63'b0, done}, 64'd1);
        check("busy_after_done", {63'b0, busy}, 64'd0);
        @(negedge clk);
        check("done_one_tick", {63'b0, done}, 64'd0);
        check("idle_no_line_start", {63'b0, line_start}, 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        start = 1'b0;
        line_done = 1'b0;
        vx0 = '0; vy0 = '0; vx1 = '0; vy1 = '0; vx2 = '0; vy2 = '0;
        repeat (3) @(negedge clk);
        check("reset_line_start", {63'b0, line_start}, 64'd0);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Plan triangles with a slow drawer.
        run_tri(0, 0, 4, 2, 0, 4, 20, 1'b0);
        run_tri(0, 0, 5, 3, 0, 3, 20, 1'b0);

        // Flat triangle, every vertex order.
        run_tri(3, 7, -2, 7, 9, 7, 20, 1'b0);
        run_tri(3, 7, 9, 7, -2, 7, 20, 1'b0);
        run_tri(-2, 7, 3, 7, 9, 7, 20, 1'b0);
        run_tri(-2, 7, 9, 7, 3, 7, 20, 1'b0);
        run_tri(9, 7, 3, 7, -2, 7, 20, 1'b0);
        run_tri(9, 7, -2, 7, 3, 7, 20, 1'b0);

        // start pulsed mid-triangle must be ignored.
        run_tri(2, 1, 10, 6, -3, 9, 20, 1'b1);

        // Reset while waiting for line_done abandons the triangle.
        pulse_start(0, 0, 4, 2, 0, 4);
        wait_ls(ok);
        check("rst_case_first_span", {63'b0, ok}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", {63'b0, busy}, 64'd0);
        check("rst_mid_line_start", {63'b0, line_start}, 64'd0);
        check("rst_mid_done", {63'b0, done}, 64'd0);
        rst = 1'b0;
        line_done = 1'b1;
        @(negedge clk);
        line_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("rst_after_quiet", {62'b0, line_start, busy}, 64'd0);
        end

        // Fresh triangle after reset, then negative coordinates.
        run_tri(0, 0, 4, 2, 0, 4, 5, 1'b0);
        run_tri(-8, -4, -1, 0, -8, 4, 20, 1'b0);

        // Random triangles with a fast drawer.
        for (int i = 0; i < 40; i++) begin
            run_tri($urandom_range(0, 24) - 12, $urandom_range(0, 24) - 12,
                    $urandom_range(0, 24) - 12, $urandom_range(0, 24) - 12,
                    $urandom_range(0, 24) - 12, $urandom_range(0, 24) - 12,
                    3, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
